// File: rtl/wavelet_pkg.sv
// Shared definitions for the wavelet output drain.
// Purpose: default parameters, the drain FSM state type, and the decode table
//          that maps the 2-bit input-length code to an input sample count.
// Ports:   none (package).
package wavelet_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_FIFO_DEPTH   = 16;
    localparam int unsigned DEF_READ_LATENCY = 2;
    localparam int unsigned DEF_GAP_CYCLES   = 4;

    // Width of all word counts (expected total, words captured).
    localparam int unsigned CNT_WIDTH = 12;

    typedef enum logic [3:0] {
        StIdle,
        StCalc,
        StRaddr,
        StWaitAvail,
        StPulse,
        StWaitLat,
        StCapture,
        StGap,
        StFlush
    } drain_state_e;

    // Input sample count for each cfg_inputs_len code.
    function automatic logic [CNT_WIDTH-1:0] decode_inputs_len(input logic [1:0] code);
        logic [CNT_WIDTH-1:0] len;
        case (code)
            2'd0:    len = 12'd256;
            2'd1:    len = 12'd512;
            2'd2:    len = 12'd1024;
            default: len = 12'd2048;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/wavelet_drain_fifo.sv
// Staging FIFO between the core read sequencer and the output stream.
// Purpose: synchronous FIFO; flags come straight from registered state so a push
//          never reaches the read side in the same cycle (no empty bypass).
//          A push is accepted while full if a pop happens in the same cycle.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data  write strobe and word
//   pop              read strobe (ignored while empty)
//   pop_data         head word, 0 while empty
//   full, empty      occupancy flags
module wavelet_drain_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wavelet_output_drain.sv
// Wavelet core output drain.
// Purpose: on start, computes how many output words the wavelet core will
//          produce for the latched configuration, resets the core read pointer,
//          then reads words one at a time (strobe, fixed latency, capture,
//          idle gap) into a staging FIFO that feeds a valid/ready stream.
//          The final word carries m_last; done pulses once the FIFO drains.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle run request (ignored while busy)
//   cfg_filter_size           filter length minus 1
//   cfg_dec_level             decomposition levels minus 1
//   cfg_inputs_len            input count code (256 << code)
//   core_r_data_available     core has an unread word
//   core_data_out             core read data, valid READ_LATENCY cycles after strobe
//   core_r_addr_rst           one-cycle core read-pointer reset
//   core_output_reg_en_pulse  one-cycle core read strobe
//   m_valid/m_ready/m_data/m_last  output stream
//   busy                      run in progress
//   done                      one-cycle end-of-run pulse
//   words_read                words captured in the current run
module wavelet_output_drain
    import wavelet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            cfg_filter_size,
    input  logic [1:0]            cfg_dec_level,
    input  logic [1:0]            cfg_inputs_len,
    input  logic                  core_r_data_available,
    input  logic [DATA_WIDTH-1:0] core_data_out,
    output logic                  core_r_addr_rst,
    output logic                  core_output_reg_en_pulse,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [11:0]           words_read
);

    localparam int unsigned LatW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned LatLast = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    drain_state_e state_q, state_d;

    logic [4:0]           cfg_filter_q;
    logic [1:0]           cfg_dec_q;
    logic [1:0]           cfg_len_q;
    logic [CNT_WIDTH-1:0] level_len_q;
    logic [CNT_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] total_q;
    logic [CNT_WIDTH-1:0] words_read_q;
    logic [1:0]           lvl_cnt_q;
    logic [LatW-1:0]      lat_cnt_q;
    logic [GapW-1:0]      gap_cnt_q;

    logic [CNT_WIDTH-1:0] prev_len;
    logic [CNT_WIDTH-1:0] next_len;
    logic                 calc_last;
    logic                 capture_last;

    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_wdata;
    logic [DATA_WIDTH:0]   fifo_rdata;

    // One decomposition level per CALC cycle: L(k) = floor((L(k-1) + F - 1) / 2),
    // and F - 1 is exactly cfg_filter_size.
    assign prev_len     = (lvl_cnt_q == 2'd0) ? decode_inputs_len(cfg_len_q) : level_len_q;
    assign next_len     = (prev_len + CNT_WIDTH'(cfg_filter_q)) >> 1;
    assign calc_last    = (lvl_cnt_q == cfg_dec_q);
    assign capture_last = ((words_read_q + 12'd1) == total_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (start) state_d = StCalc;
            StCalc:      if (calc_last) state_d = StRaddr;
            StRaddr:     state_d = StWaitAvail;
            StWaitAvail: if (core_r_data_available && !fifo_full) state_d = StPulse;
            StPulse:     state_d = (READ_LATENCY > 1) ? StWaitLat : StCapture;
            StWaitLat:   if (lat_cnt_q == LatW'(LatLast)) state_d = StCapture;
            StCapture:   state_d = capture_last ? StFlush : StGap;
            StGap:       if (gap_cnt_q == GapW'(GapLast)) state_d = StWaitAvail;
            StFlush:     if (fifo_empty) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        core_r_addr_rst          = (state_q == StRaddr);
        core_output_reg_en_pulse = (state_q == StPulse);
        done                     = (state_q == StFlush) && fifo_empty;
        busy                     = (state_q != StIdle) && !done;
    end

    // Datapath: config latch, length calculation, counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_filter_q <= '0;
            cfg_dec_q    <= '0;
            cfg_len_q    <= '0;
            level_len_q  <= '0;
            acc_q        <= '0;
            total_q      <= '0;
            words_read_q <= '0;
            lvl_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cfg_filter_q <= cfg_filter_size;
                        cfg_dec_q    <= cfg_dec_level;
                        cfg_len_q    <= cfg_inputs_len;
                        words_read_q <= '0;
                        acc_q        <= '0;
                        total_q      <= '0;
                        lvl_cnt_q    <= '0;
                    end
                end
                StCalc: begin
                    level_len_q <= next_len;
                    acc_q       <= acc_q + next_len;
                    lvl_cnt_q   <= lvl_cnt_q + 2'd1;
                    // The deepest level is counted twice (detail + approximation).
                    if (calc_last) begin
                        total_q <= acc_q + next_len + next_len;
                    end
                end
                StPulse:   lat_cnt_q <= '0;
                StWaitLat: lat_cnt_q <= lat_cnt_q + LatW'(1);
                StCapture: begin
                    words_read_q <= words_read_q + 12'd1;
                    gap_cnt_q    <= '0;
                end
                StGap:     gap_cnt_q <= gap_cnt_q + GapW'(1);
                default: ;
            endcase
        end
    end

    assign words_read = words_read_q;

    // The FIFO write itself is the capture register for core_data_out.
    assign fifo_push  = (state_q == StCapture);
    assign fifo_wdata = {capture_last, core_data_out};

    wavelet_drain_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (m_ready),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid          = !fifo_empty;
    assign {m_last, m_data} = fifo_rdata;

endmodule

// File: tb/tb_wavelet_output_drain.sv
module tb_wavelet_output_drain;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned RL    = 2;
    localparam int unsigned GAP   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    cfg_filter_size;
    logic [1:0]    cfg_dec_level;
    logic [1:0]    cfg_inputs_len;
    logic          core_r_data_available;
    logic [DW-1:0] core_data_out;
    logic          core_r_addr_rst;
    logic          core_output_reg_en_pulse;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    logic [11:0]   words_read;

    always #5 clk = ~clk;

    wavelet_output_drain #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .READ_LATENCY (RL),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .cfg_filter_size          (cfg_filter_size),
        .cfg_dec_level            (cfg_dec_level),
        .cfg_inputs_len           (cfg_inputs_len),
        .core_r_data_available    (core_r_data_available),
        .core_data_out            (core_data_out),
        .core_r_addr_rst          (core_r_addr_rst),
        .core_output_reg_en_pulse (core_output_reg_en_pulse),
        .m_valid                  (m_valid),
        .m_ready                  (m_ready),
        .m_data                   (m_data),
        .m_last                   (m_last),
        .busy                     (busy),
        .done                     (done),
        .words_read               (words_read)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected word count straight from the level-length recurrence.
    function automatic int ref_total(input int f_m1, input int dec, input int code);
        int len;
        int sum;
        len = 256 * (1 << code);
        sum = 0;
        for (int k = 1; k <= dec + 1; k++) begin
            len = (len + (f_m1 + 1) - 1) / 2;
            sum += len;
        end
        return sum + len;
    endfunction

    // Core model / stream scoreboard state
    int          cyc = 0;
    int          pulses, addr_rsts, dones, words_out;
    int          first_pulse_cyc, last_pulse_cyc, addr_rst_cyc, min_spacing, max_outst;
    int          exp_total = 0;
    logic [31:0] exp_q[$];
    bit          pending = 0;
    int          due;
    logic [31:0] pend_val;
    logic [31:0] core_ctr = 32'h1000;
    bit          avail_rand = 0;
    bit          ready_rand = 0;
    int          stall_at = -1;
    int          stall_len = 0;
    int          stall_left = 0;
    bit          stall_done = 0;
    bit          prev_stall = 0;
    logic [32:0] prev_word;

    always @(negedge clk) begin
        cyc++;
        // Core returns an incrementing counter exactly RL cycles after the strobe.
        if (pending && cyc == due) begin
            core_data_out = pend_val;
            pending = 0;
        end else begin
            core_data_out = 32'hBAD0_0000 | 32'(cyc[15:0]);
        end
        if (core_output_reg_en_pulse) begin
            check("one_read_in_flight", pending, 0);
            if (last_pulse_cyc >= 0 && cyc - last_pulse_cyc < min_spacing)
                min_spacing = cyc - last_pulse_cyc;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
            last_pulse_cyc = cyc;
            pulses++;
            pend_val = core_ctr;
            core_ctr++;
            due = cyc + int'(RL);
            pending = 1;
            exp_q.push_back(pend_val);
        end
        if (core_r_addr_rst) begin
            addr_rsts++;
            addr_rst_cyc = cyc;
        end
        if (done) begin
            dones++;
            check("busy_low_with_done", busy, 0);
        end
        if (pulses - words_out > max_outst) max_outst = pulses - words_out;

        core_r_data_available = avail_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
        end else if (!stall_done && stall_at >= 0 && words_out == stall_at) begin
            m_ready = 1'b0;
            stall_left = stall_len - 1;
            stall_done = 1;
        end else begin
            m_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end

        if (prev_stall) begin
            check("valid_held", m_valid, 1);
            check("word_held", {m_last, m_data}, prev_word);
        end
        if (m_valid && m_ready) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("data", m_data, exp_q.pop_front());
                check("last", m_last, words_out == exp_total - 1);
            end
            words_out++;
        end
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_last, m_data};
    end

    task automatic begin_run(input int fm1, input int dec, input int code, input bit a_rand,
                             input bit r_rand, input int s_at, input int s_len);
        @(negedge clk);
        pulses = 0; addr_rsts = 0; dones = 0; words_out = 0;
        first_pulse_cyc = -1; last_pulse_cyc = -1; addr_rst_cyc = -1;
        min_spacing = 1000000; max_outst = 0;
        exp_q.delete();
        pending = 0;
        avail_rand = a_rand; ready_rand = r_rand;
        stall_at = s_at; stall_len = s_len; stall_left = 0; stall_done = 0;
        exp_total = ref_total(fm1, dec, code);
        cfg_filter_size = 5'(fm1);
        cfg_dec_level   = 2'(dec);
        cfg_inputs_len  = 2'(code);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Config must have been latched; scramble the live inputs.
        cfg_filter_size = 5'($urandom);
        cfg_dec_level   = 2'($urandom);
        cfg_inputs_len  = 2'($urandom);
    endtask

    task automatic run_drain(input string name, input int fm1, input int dec, input int code,
                             input bit a_rand, input bit r_rand, input int s_at, input int s_len,
                             input bit restart);
        begin_run(fm1, dec, code, a_rand, r_rand, s_at, s_len);
        if (restart) begin
            repeat (40) @(negedge clk);
            cfg_filter_size = 5'd0;
            cfg_dec_level   = 2'd0;
            cfg_inputs_len  = 2'd3;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 20000 && dones == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({name, ":words_out"}, words_out, exp_total);
        check({name, ":pulses"}, pulses, exp_total);
        check({name, ":done_count"}, dones, 1);
        check({name, ":words_read"}, words_read, exp_total);
        check({name, ":busy_after"}, busy, 0);
        check({name, ":addr_rst_count"}, addr_rsts, 1);
        check({name, ":addr_rst_first"}, addr_rst_cyc >= 0 && addr_rst_cyc < first_pulse_cyc, 1);
        check({name, ":pulse_spacing"}, min_spacing >= int'(3 + GAP), 1);
        check({name, ":fifo_bound"}, max_outst <= int'(DEPTH), 1);
        check({name, ":scoreboard_empty"}, exp_q.size(), 0);
    endtask

    task automatic reset_midrun();
        int base_pulses;
        int base_rsts;
        begin_run(3, 3, 0, 0, 0, -1, 0);
        for (int i = 0; i < 5000 && pulses < 11; i++) @(posedge clk);
        #2;
        check("rst:words_before", words_read, 10);
        rst = 1'b1;
        #1;
        check("rst:busy", busy, 0);
        check("rst:m_valid", m_valid, 0);
        check("rst:m_data", m_data, 0);
        check("rst:m_last", m_last, 0);
        check("rst:pulse", core_output_reg_en_pulse, 0);
        check("rst:addr_rst", core_r_addr_rst, 0);
        check("rst:done", done, 0);
        check("rst:words_read", words_read, 0);
        exp_q.delete();
        pending = 0;
        base_pulses = pulses;
        base_rsts = addr_rsts;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst:no_pulse_after", pulses, base_pulses);
        check("rst:no_addr_rst_after", addr_rsts, base_rsts);
        check("rst:idle_after", busy, 0);
        check("rst:no_done", dones, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_filter_size = '0;
        cfg_dec_level = '0;
        cfg_inputs_len = '0;
        core_r_data_available = 1'b0;
        core_data_out = '0;
        m_ready = 1'b0;
        #1;
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:m_valid", m_valid, 0);
        check("reset:m_last", m_last, 0);
        check("reset:m_data", m_data, 0);
        check("reset:pulse", core_output_reg_en_pulse, 0);
        check("reset:addr_rst", core_r_addr_rst, 0);
        check("reset:words_read", words_read, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("model:f4_d3", ref_total(3, 3, 0), 265);
        check("model:f4_d0", ref_total(3, 0, 0), 258);

        run_drain("f4_d3", 3, 3, 0, 0, 0, -1, 0, 0);
        run_drain("f4_d0", 3, 0, 0, 0, 0, -1, 0, 0);
        run_drain("stall40", 3, 3, 0, 0, 0, 20, 40, 0);
        run_drain("stall_long", 3, 2, 0, 0, 0, 5, 200, 0);
        check("stall_long:fifo_filled", max_outst, DEPTH);
        run_drain("rand_a", int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 0,
                  1, 1, -1, 0, 0);
        run_drain("rand_b", int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1,
                  1, 1, -1, 0, 0);
        run_drain("restart", 3, 3, 0, 1, 0, -1, 0, 1);
        reset_midrun();
        run_drain("after_rst", 3, 3, 0, 0, 1, -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wavelet_output_drain.md
WAVELET_OUTPUT_DRAIN -- requirements
Module: wavelet_output_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of core output words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of 2): depth of the output staging FIFO.
REQ-003 SHALL have parameter READ_LATENCY, default 2: cycles from read pulse to valid core_data_out.
REQ-004 SHALL have parameter GAP_CYCLES, default 4 (min 1): idle cycles after each capture before re-sampling core_r_data_available.
REQ-005 SHALL have port clk  in  1  the single clock.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a drain run.
REQ-008 SHALL have port cfg_filter_size  in  5  filter length minus 1.
REQ-009 SHALL have port cfg_dec_level  in  2  decomposition levels minus 1.
REQ-010 SHALL have port cfg_inputs_len  in  2  input count code: 0->256, 1->512, 2->1024, 3->2048.
REQ-011 SHALL have port core_r_data_available  in  1  core has an unread output word.
REQ-012 SHALL have port core_data_out  in  DATA_WIDTH  core read data.
REQ-013 SHALL have port core_r_addr_rst  out  1  one-cycle core read-pointer reset.
REQ-014 SHALL have port core_output_reg_en_pulse  out  1  one-cycle core read strobe.
REQ-015 SHALL have port m_valid / m_ready / m_data (DATA_WIDTH) / m_last  out/in/out/out  output stream; m_last marks final word.
REQ-016 SHALL have port busy  out  1  high from start acceptance until DONE.
REQ-017 SHALL have port done  out  1  one-cycle pulse when the last word leaves the FIFO.
REQ-018 SHALL have port words_read  out  12  count of words captured this run.

Function
REQ-019 SHALL implement states IDLE, CALC, RADDR, WAIT_AVAIL, PULSE, WAIT_LAT, CAPTURE, GAP, FLUSH.
REQ-020 IDLE: start=1 -> CALC, latch cfg_*, clear words_read; start while busy SHALL be ignored.
REQ-021 CALC: compute the expected count iteratively, one level per cycle; F=cfg_filter_size+1, L0=N, Lk=floor((L(k-1)+F-1)/2), total = L1+...+Ln + Ln with n=cfg_dec_level+1; 12-bit arithmetic, no saturation needed for legal configs.
REQ-022 RADDR: assert core_r_addr_rst for exactly one cycle -> WAIT_AVAIL.
REQ-023 WAIT_AVAIL: core_r_data_available=1 and FIFO not full -> PULSE; otherwise hold.
REQ-024 PULSE: assert core_output_reg_en_pulse for exactly one cycle; at most one read in flight.
REQ-025 WAIT_LAT: wait READ_LATENCY-1 cycles; CAPTURE registers core_data_out exactly READ_LATENCY cycles after the pulse cycle and pushes into FIFO; words_read increments.
REQ-026 After CAPTURE: words_read==total -> FLUSH; else GAP for GAP_CYCLES, then WAIT_AVAIL.
REQ-027 The FIFO word whose index equals total-1 SHALL carry m_last=1; all others 0.
REQ-028 Stream: word transfers when m_valid&&m_ready; m_data/m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-029 FIFO push and pop in the same cycle SHALL be legal when full or empty-bypass-free (no combinational path from push to m_valid).
REQ-030 FLUSH: FIFO empties -> pulse done, return to IDLE; busy drops the same cycle done pulses.
REQ-031 core_r_data_available dropping while in WAIT_AVAIL SHALL stall indefinitely without error.

Reset
REQ-032 rst SHALL asynchronously force state IDLE, all outputs 0, FIFO empty, words_read 0, latched config 0.
REQ-033 rst mid-run SHALL abort without emitting any further pulse; a captured-but-unpopped word is discarded.

Structure
REQ-034 Input-length decode table, state enum and default parameters SHALL live in shared package wavelet_pkg.
REQ-035 The staging FIFO SHALL be sub-module wavelet_drain_fifo (synchronous, registered outputs, full/empty flags).

Verification
REQ-036 F=4, dec_level=3, len=0, core model always available, m_ready=1 -> exactly 265 words, last word has m_last=1, done once.
REQ-037 F=4, dec_level=0, len=0 -> 258 words; core_r_addr_rst seen once, before the first read pulse.
REQ-038 m_ready=0 for 40 cycles mid-run, FIFO_DEPTH=16 -> pulses stop after 16 words in FIFO, resume on ready, no data lost or reordered.
REQ-039 Core model with READ_LATENCY=2 returning an incrementing counter -> captured values match read order exactly; pulse spacing >= 3+GAP_CYCLES.
REQ-040 rst asserted during WAIT_LAT after word 10 -> outputs 0 immediately, no pulse afterwards; a new start yields a full correct run.
REQ-041 start pulsed while busy -> ignored; words_read and total unaffected.
